// File: rtl/fixed_point_issue_unit_pkg.sv
// Shared encodings for the fixed-point issue unit: FPU operation codes and
// FSM state encodings.
package fixed_point_issue_unit_pkg;

  // FPU operation codes presented on issue_operation / fpu_operation
  localparam logic [1:0] FpuAdd  = 2'b00;
  localparam logic [1:0] FpuSub  = 2'b01;
  localparam logic [1:0] FpuMul  = 2'b10;
  localparam logic [1:0] FpuSqrt = 2'b11;

  // FSM state encodings
  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StLaunch = 2'b01;
  localparam logic [1:0] StWait   = 2'b10;
  localparam logic [1:0] StWb     = 2'b11;

  // ADD/SUB complete combinationally in the FPU; MUL/SQRT need a handshake
  function automatic logic is_single_cycle(logic [1:0] op);
    return (op == FpuAdd) || (op == FpuSub);
  endfunction

endpackage

// File: rtl/fixed_point_issue_unit.sv
// Issue unit that hands one fixed-point instruction at a time to an external
// FPU, waits for its result (with a bounded wait), and writes it back.
module fixed_point_issue_unit
  import fixed_point_issue_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FBITS   = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [1:0]       issue_operation,
  input  logic [WIDTH-1:0] issue_operand_1,
  input  logic [WIDTH-1:0] issue_operand_2,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  // FBITS only documents the number format; reject nonsensical values
  if (FBITS > WIDTH) begin : g_fbits_check
    $error("FBITS must not exceed WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             accept;
  logic             wait_expired;

  // Flush blocks acceptance so a flushed cycle can never launch new work
  assign issue_ready  = ((state_q == StIdle) || (state_q == StWb)) && !flush;
  assign accept       = issue_valid && issue_ready;
  assign busy         = issue_valid && !issue_ready;
  assign wait_expired = (state_q == StWait) && !fpu_ready && (cnt_q == CntMax);

  // Next-state, wait counter and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StLaunch;
      end
      StLaunch: begin
        // fpu_ready may still be high from a previous op; only op type matters here
        if (is_single_cycle(op_q)) begin
          res_d   = fpu_result;
          state_d = StWb;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (fpu_ready) begin
          res_d   = fpu_result;
          state_d = StWb;
        end else if (wait_expired) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        state_d = accept ? StLaunch : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // FSM state, wait counter and captured result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Holding registers: change only when an instruction is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= issue_operation;
      opa_q <= issue_operand_1;
      opb_q <= issue_operand_2;
      rd_q  <= issue_rd;
    end
  end

  assign fpu_operation = op_q;
  assign fpu_operand_1 = opa_q;
  assign fpu_operand_2 = opb_q;

  // x0 is hardwired zero, so writes to it are dropped
  assign wb_valid    = (state_q == StWb) && (rd_q != 5'd0) && !flush;
  assign wb_rd       = rd_q;
  assign wb_data     = res_q;
  assign timeout_err = wait_expired && !flush;

endmodule

// File: tb/tb_fixed_point_issue_unit.sv
// Self-checking bench for fixed_point_issue_unit: directed vector table,
// hand-written corner sequences, and randomized traffic against a
// schedule-based reference model.
module tb_fixed_point_issue_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [1:0] OpAdd  = 2'b00;
  localparam logic [1:0] OpSub  = 2'b01;
  localparam logic [1:0] OpMul  = 2'b10;
  localparam logic [1:0] OpSqrt = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [1:0]       issue_operation;
  logic [WIDTH-1:0] issue_operand_1, issue_operand_2;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic             flush;
  logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             busy;
  logic             timeout_err;

  fixed_point_issue_unit #(
    .WIDTH  (WIDTH),
    .FBITS  (10),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_operation(issue_operation),
    .issue_operand_1(issue_operand_1),
    .issue_operand_2(issue_operand_2),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .flush          (flush),
    .fpu_operand_1  (fpu_operand_1),
    .fpu_operand_2  (fpu_operand_2),
    .fpu_operation  (fpu_operation),
    .fpu_result     (fpu_result),
    .fpu_ready      (fpu_ready),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    issue_valid     = v;
    issue_operation = op;
    issue_operand_1 = a;
    issue_operand_2 = b;
    issue_rd        = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    fpu_ready = 1'b0;
    fpu_result = '0;
    drive(1'b0, OpAdd, '0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        fr;
    logic [31:0] res;
    logic        e_rdy, e_busy, e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [1:0]  e_op;
    logic [31:0] e_a, e_b;
  } vec_t;

  function automatic vec_t v(logic iv, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                             logic [4:0] rd, logic fr, logic [31:0] res, logic e_rdy,
                             logic e_busy, logic e_wb, logic [4:0] e_rd, logic [31:0] e_data,
                             logic [1:0] e_op, logic [31:0] e_a, logic [31:0] e_b);
    vec_t r;
    r.iv = iv; r.op = op; r.a = a; r.b = b; r.rd = rd; r.fr = fr; r.res = res;
    r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_wb = e_wb; r.e_rd = e_rd; r.e_data = e_data;
    r.e_op = e_op; r.e_a = e_a; r.e_b = e_b;
    return r;
  endfunction

  vec_t vecs[17];

  // Reference schedule for randomized traffic (cycle numbers; -1 = none)
  int free_c, p_launch, p_cap, p_rdy, p_wait_end, p_wb, p_err;
  logic [1:0]  p_op;
  logic [31:0] p_a, p_b, p_data;
  logic [4:0]  p_rd;
  logic        exp_rdy;

  initial begin
    // ADD / back-to-back SUB / MUL with stale ready, one row per cycle
    vecs[0]  = v(1, OpAdd, 32'h600, 32'h800, 5, 0, 0,            1, 0, 0, 0, 0,        OpAdd, 0, 0);
    vecs[1]  = v(0, OpAdd, 0, 0, 0,            0, 32'hE00,       0, 0, 0, 0, 0,        OpAdd, 32'h600, 32'h800);
    vecs[2]  = v(0, OpAdd, 0, 0, 0,            0, 0,             1, 0, 1, 5, 32'hE00,  OpAdd, 32'h600, 32'h800);
    vecs[3]  = v(1, OpSub, 32'h1000, 32'h10, 3, 0, 0,            1, 0, 0, 0, 0,        OpAdd, 32'h600, 32'h800);
    vecs[4]  = v(1, OpSub, 32'h2000, 32'h20, 0, 0, 32'h111,      0, 1, 0, 0, 0,        OpSub, 32'h1000, 32'h10);
    vecs[5]  = v(1, OpSub, 32'h2000, 32'h20, 0, 0, 0,            1, 0, 1, 3, 32'h111,  OpSub, 32'h1000, 32'h10);
    vecs[6]  = v(0, OpAdd, 0, 0, 0,            0, 32'h222,       0, 0, 0, 0, 0,        OpSub, 32'h2000, 32'h20);
    vecs[7]  = v(0, OpAdd, 0, 0, 0,            0, 0,             1, 0, 0, 0, 0,        OpSub, 32'h2000, 32'h20);
    vecs[8]  = v(1, OpMul, 32'h600, 32'h800, 7, 0, 0,            1, 0, 0, 0, 0,        OpSub, 32'h2000, 32'h20);
    vecs[9]  = v(1, OpAdd, 1, 1, 1,            1, 32'hDEAD,      0, 1, 0, 0, 0,        OpMul, 32'h600, 32'h800);
    for (int i = 10; i < 14; i++)
      vecs[i] = v(1, OpAdd, 1, 1, 1,           0, 32'hDEAD,      0, 1, 0, 0, 0,        OpMul, 32'h600, 32'h800);
    vecs[14] = v(1, OpAdd, 1, 1, 1,            1, 32'hC00,       0, 1, 0, 0, 0,        OpMul, 32'h600, 32'h800);
    vecs[15] = v(0, OpAdd, 0, 0, 0,            0, 0,             1, 0, 1, 7, 32'hC00,  OpMul, 32'h600, 32'h800);
    vecs[16] = v(0, OpAdd, 0, 0, 0,            0, 0,             1, 0, 0, 0, 0,        OpMul, 32'h600, 32'h800);

    do_reset();
    #1;
    chk1("rst_issue_ready", issue_ready, 1'b1);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chk32("rst_fpu_operand_1", fpu_operand_1, 32'h0);
    chk32("rst_fpu_operand_2", fpu_operand_2, 32'h0);
    chk32("rst_fpu_operation", 32'(fpu_operation), 32'h0);
    chk32("rst_wb_data", wb_data, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      fpu_ready  = vecs[i].fr;
      fpu_result = vecs[i].res;
      #1;
      chk1($sformatf("vec%0d_issue_ready", i), issue_ready, vecs[i].e_rdy);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk1($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].e_wb);
      chk1($sformatf("vec%0d_timeout_err", i), timeout_err, 1'b0);
      chk32($sformatf("vec%0d_fpu_operation", i), 32'(fpu_operation), 32'(vecs[i].e_op));
      chk32($sformatf("vec%0d_fpu_operand_1", i), fpu_operand_1, vecs[i].e_a);
      chk32($sformatf("vec%0d_fpu_operand_2", i), fpu_operand_2, vecs[i].e_b);
      if (vecs[i].e_wb) begin
        chk32($sformatf("vec%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
        chk32($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].e_data);
      end
    end

    // SQRT that never completes: 64 WAIT cycles then an abort pulse
    @(negedge clk);
    drive(1'b1, OpSqrt, 32'h900, 32'h0, 5'd9);
    fpu_ready = 1'b0;
    #1;
    chk1("sqrt_accept_ready", issue_ready, 1'b1);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      drive(1'b0, OpAdd, '0, '0, '0);
      fpu_ready = 1'b0;
      #1;
      chk1($sformatf("to%0d_timeout_err", k), timeout_err, k == 65);
      chk1($sformatf("to%0d_wb_valid", k), wb_valid, 1'b0);
      chk1($sformatf("to%0d_issue_ready", k), issue_ready, k == 66);
    end

    // Flush in WAIT while the FPU reports ready: result is discarded
    @(negedge clk);
    drive(1'b1, OpMul, 32'h333, 32'h3, 5'd4);
    #1;
    chk1("fl_accept_ready", issue_ready, 1'b1);
    repeat (2) begin
      @(negedge clk);
      drive(1'b0, OpAdd, '0, '0, '0);
      fpu_ready = 1'b0;
    end
    @(negedge clk);
    drive(1'b1, OpAdd, 32'h55, 32'h55, 5'd8);
    flush = 1'b1;
    fpu_ready = 1'b1;
    fpu_result = 32'hBAD;
    #1;
    chk1("fl_wait_issue_ready", issue_ready, 1'b0);
    chk1("fl_wait_busy", busy, 1'b1);
    chk1("fl_wait_wb_valid", wb_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, OpAdd, '0, '0, '0);
      fpu_ready = 1'b1;
      #1;
      chk1($sformatf("fl_after%0d_issue_ready", k), issue_ready, 1'b1);
      chk1($sformatf("fl_after%0d_wb_valid", k), wb_valid, 1'b0);
    end

    // Flush beats a simultaneous issue in IDLE
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, OpAdd, 32'hABC, 32'h1, 5'd2);
    #1;
    chk1("fl_idle_issue_ready", issue_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, OpAdd, '0, '0, '0);
      #1;
      chk32($sformatf("fl_idle%0d_fpu_operand_1", k), fpu_operand_1, 32'h333);
      chk1($sformatf("fl_idle%0d_wb_valid", k), wb_valid, 1'b0);
    end

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    drive(1'b1, OpMul, 32'h444, 32'h4, 5'd6);
    fpu_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, OpAdd, '0, '0, '0);
    end
    #1;
    reset = 1'b1;
    #1;
    chk1("rw_wb_valid", wb_valid, 1'b0);
    chk1("rw_timeout_err", timeout_err, 1'b0);
    chk32("rw_fpu_operand_1", fpu_operand_1, 32'h0);
    chk32("rw_fpu_operation", 32'(fpu_operation), 32'h0);
    chk32("rw_wb_data", wb_data, 32'h0);
    chk32("rw_wb_rd", 32'(wb_rd), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fpu_ready = 1'b1;
      #1;
      chk1($sformatf("rw_after%0d_wb_valid", k), wb_valid, 1'b0);
      chk1($sformatf("rw_after%0d_issue_ready", k), issue_ready, 1'b1);
    end

    // Randomized traffic against a cycle-schedule reference model
    do_reset();
    free_c = 0; p_launch = -1; p_cap = -1; p_rdy = -1; p_wait_end = -1; p_wb = -1; p_err = -1;
    p_op = OpAdd; p_a = '0; p_b = '0; p_rd = '0; p_data = '0;
    for (int c = 0; c < 600; c++) begin
      int d;
      @(negedge clk);
      if (p_launch >= 0 && c > p_launch && c < p_wait_end) fpu_ready = 1'b0;
      else if (c == p_rdy) fpu_ready = 1'b1;
      else fpu_ready = 1'($urandom_range(1));
      fpu_result = $urandom;
      if (c == p_cap) p_data = fpu_result;
      exp_rdy = (c >= free_c);
      drive(($urandom_range(9) < 7), 2'($urandom_range(3)), $urandom, $urandom,
            5'($urandom_range(31)));
      #1;
      chk1($sformatf("rnd%0d_issue_ready", c), issue_ready, exp_rdy);
      chk1($sformatf("rnd%0d_busy", c), busy, issue_valid && !exp_rdy);
      chk1($sformatf("rnd%0d_wb_valid", c), wb_valid, (c == p_wb) && (p_rd != 5'd0));
      chk1($sformatf("rnd%0d_timeout_err", c), timeout_err, c == p_err);
      if (c == p_wb && p_rd != 5'd0) begin
        chk32($sformatf("rnd%0d_wb_rd", c), 32'(wb_rd), 32'(p_rd));
        chk32($sformatf("rnd%0d_wb_data", c), wb_data, p_data);
      end
      if (p_launch >= 0 && c >= p_launch) begin
        chk32($sformatf("rnd%0d_fpu_operation", c), 32'(fpu_operation), 32'(p_op));
        chk32($sformatf("rnd%0d_fpu_operand_1", c), fpu_operand_1, p_a);
        chk32($sformatf("rnd%0d_fpu_operand_2", c), fpu_operand_2, p_b);
      end
      if (issue_valid && exp_rdy) begin
        p_op = issue_operation; p_a = issue_operand_1; p_b = issue_operand_2; p_rd = issue_rd;
        p_launch = c + 1;
        if (issue_operation == OpAdd || issue_operation == OpSub) begin
          p_cap = c + 1; p_wb = c + 2; free_c = c + 2;
          p_err = -1; p_rdy = -1; p_wait_end = -1;
        end else if ($urandom_range(15) == 0) begin
          p_err = c + 2 + int'(TIMEOUT) - 1; free_c = p_err + 1;
          p_wb = -1; p_cap = -1; p_rdy = -1; p_wait_end = p_err + 1;
        end else begin
          d = int'($urandom_range(6));
          p_rdy = c + 2 + d; p_cap = p_rdy; p_wb = p_rdy + 1; free_c = p_wb;
          p_wait_end = p_rdy; p_err = -1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fixed_point_issue_unit.md
FIXED_POINT_ISSUE_UNIT -- requirements
Module: Fixed_Point_Issue_Unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter FBITS, default 10, fraction bits (passed through for documentation only, no arithmetic).
REQ-003 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before abort.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue_valid  input  1  decode presents FPU instruction.
REQ-007 SHALL have port issue_operation  input  2  FPU_ADD/SUB/MUL/SQRT code.
REQ-008 SHALL have ports issue_operand_1, issue_operand_2  input  WIDTH  source operands.
REQ-009 SHALL have port issue_rd  input  5  destination register index.
REQ-010 SHALL have port issue_ready  output  1  instruction accepted when issue_valid && issue_ready.
REQ-011 SHALL have port flush  input  1  abort in-flight instruction.
REQ-012 SHALL have ports fpu_operand_1, fpu_operand_2 (output, WIDTH) and fpu_operation (output, 2), held stable to the FPU.
REQ-013 SHALL have ports fpu_result  input  WIDTH and fpu_ready  input  1  from FPU.
REQ-014 SHALL have ports wb_valid (output, 1), wb_rd (output, 5), wb_data (output, WIDTH)  register-file write.
REQ-015 SHALL have ports busy (output, 1) pipeline stall, and timeout_err (output, 1) one-cycle abort pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LAUNCH, WAIT, WB.
REQ-017 IDLE: issue_ready=1; on accept, latch operation/operands/rd into holding registers, go LAUNCH.
REQ-018 LAUNCH: fpu_* driven from holding registers; ADD/SUB capture fpu_result this cycle and go WB; MUL/SQRT go WAIT, fpu_ready ignored in LAUNCH (may be stale).
REQ-019 WAIT: on fpu_ready=1 capture fpu_result, go WB; else increment wait counter.
REQ-020 WAIT: when counter reaches TIMEOUT-1 with fpu_ready=0, pulse timeout_err one cycle, no writeback, go IDLE.
REQ-021 WB: wb_valid=1 for exactly one cycle with wb_rd/wb_data from holding registers; wb_valid suppressed when rd=0.
REQ-022 WB: issue_ready=1; accepted instruction goes directly to LAUNCH (back-to-back), else IDLE.
REQ-023 issue_ready SHALL be 0 in LAUNCH and WAIT; busy = issue_valid && !issue_ready.
REQ-024 fpu_operand_*/fpu_operation SHALL change only on accept; held constant LAUNCH through WB.
REQ-025 Latency: ADD/SUB accept cycle N -> wb_valid at N+2; MUL/SQRT -> wb_valid one cycle after first fpu_ready seen in WAIT.
REQ-026 flush (any state) SHALL force IDLE next cycle, cancel wb_valid and timeout_err, clear counter; flush wins over simultaneous accept (issue_ready=0 while flush=1).
REQ-027 Counter SHALL be $clog2(TIMEOUT) bits, cleared on entry to WAIT.
REQ-028 No arithmetic on operands; results passed unmodified.

Reset
REQ-029 reset SHALL asynchronously force IDLE, counter=0, holding registers=0, wb_valid=0, timeout_err=0, fpu_* outputs=0, issue_ready=1 after release.
REQ-030 Reset mid-WAIT SHALL discard the instruction with no writeback and no error pulse.

Structure
REQ-031 FPU_ADD/SUB/MUL/SQRT codes and FSM state encodings SHALL live in shared Defines.vh.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 ADD 0x00000600 + 0x00000800, rd=5 -> wb_valid at N+2, wb_rd=5, wb_data=0x00000E00.
REQ-034 MUL 0x00000600 * 0x00000800, FPU model ready after 4 cycles -> wb_data=0x00000C00, busy high throughout, stale fpu_ready=1 in LAUNCH ignored.
REQ-035 SQRT with fpu_ready held 0 -> timeout_err pulse after 64 WAIT cycles, no wb_valid, issue_ready=1 next cycle.
REQ-036 Two back-to-back SUB (rd=3, rd=0) -> second accepted in WB cycle; one wb_valid (rd=3) only.
REQ-037 flush asserted in WAIT together with fpu_ready=1 -> no wb_valid, IDLE next cycle.
REQ-038 reset pulsed mid-WAIT -> all outputs zero immediately, no writeback after release.
